// File: rtl/md_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package md_pkg;

   // funct3 encodings of the M-extension operations
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   // One iteration per operand bit
   localparam int unsigned MD_ITERS = 32;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StDone
   } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative datapath: shift-add multiply or restoring divide, one step per cycle.
// Multiply: acc = {product_hi, multiplier/product_lo}, opd = multiplicand.
// Divide:   acc = {remainder, dividend/quotient},      opd = divisor.
module md_iter_core #(
   parameter int unsigned Width = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               div_mode_i,
   input  logic [2*Width-1:0] acc_init_i,
   input  logic [Width-1:0]   opd_init_i,
   output logic [2*Width-1:0] acc_o
);

   logic [2*Width-1:0] acc_q, acc_d;
   logic [Width-1:0]   opd_q, opd_d;
   logic [Width:0]     mul_sum;
   logic [2*Width-1:0] mul_next;
   logic [Width:0]     rem_sh;
   logic [Width:0]     trial;
   logic [2*Width-1:0] div_next;

   // Single-step next values for both modes, then load/step selection
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_next = {mul_sum, acc_q[Width-1:1]};

      rem_sh = {acc_q[2*Width-1:Width], acc_q[Width-1]};
      trial  = rem_sh - {1'b0, opd_q};
      // MSB of trial set means the divisor did not fit: keep the shifted remainder
      if (trial[Width]) begin
         div_next = {rem_sh[Width-1:0], acc_q[Width-2:0], 1'b0};
      end else begin
         div_next = {trial[Width-1:0], acc_q[Width-2:0], 1'b1};
      end

      acc_d = acc_q;
      opd_d = opd_q;
      if (load_i) begin
         acc_d = acc_init_i;
         opd_d = opd_init_i;
      end else if (step_i) begin
         acc_d = div_mode_i ? div_next : mul_next;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         opd_q <= '0;
      end else begin
         acc_q <= acc_d;
         opd_q <= opd_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/md_sequencer.sv
// RV32M multiply/divide sequencer: captures an op from execute, stalls the
// front of the pipe while md_iter_core iterates, then presents the result
// for exactly one cycle.
module md_sequencer
   import md_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MD_ITERS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_e,
   input  logic [2:0]            funct3_e,
   input  logic [DATA_WIDTH-1:0] src_a_e,
   input  logic [DATA_WIDTH-1:0] src_b_e,
   input  logic                  flush_e,
   output logic                  stall_md,
   output logic                  done_e,
   output logic [DATA_WIDTH-1:0] md_result_e
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(DATA_WIDTH);
   localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

   md_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            neg_q, neg_d;
   logic            neg_rem_q, neg_rem_d;

   logic           a_signed, b_signed, a_neg, b_neg;
   logic [W-1:0]   a_mag, b_mag;
   logic           is_div, div_zero, div_ovf, special;
   logic [2*W-1:0] acc_init;
   logic [W-1:0]   opd_init;
   logic           load, step;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo, rem;

   // Operand magnitudes, sign flags and divide special cases from the live inputs
   always_comb begin
      a_signed = (funct3_e == MD_MULH) || (funct3_e == MD_MULHSU) ||
                 (funct3_e == MD_DIV)  || (funct3_e == MD_REM);
      b_signed = (funct3_e == MD_MULH) || (funct3_e == MD_DIV) || (funct3_e == MD_REM);
      a_neg    = a_signed & src_a_e[W-1];
      b_neg    = b_signed & src_b_e[W-1];
      a_mag    = a_neg ? -src_a_e : src_a_e;
      b_mag    = b_neg ? -src_b_e : src_b_e;

      is_div   = funct3_e[2];
      div_zero = (src_b_e == '0);
      div_ovf  = !funct3_e[0] && (src_a_e == MinNeg) && (src_b_e == '1);
      special  = is_div && (div_zero || div_ovf);

      // Special cases preload the final {remainder, quotient} with no sign fixup
      if (special) begin
         acc_init = div_zero ? {src_a_e, {W{1'b1}}} : {{W{1'b0}}, src_a_e};
      end else if (is_div) begin
         acc_init = {{W{1'b0}}, a_mag};
      end else begin
         acc_init = {{W{1'b0}}, b_mag};
      end
      opd_init = is_div ? b_mag : a_mag;
   end

   // FSM next-state, counter and capture
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      load      = 1'b0;
      step      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_e && !flush_e) begin
               load      = 1'b1;
               op_d      = funct3_e;
               neg_d     = special ? 1'b0 : (a_neg ^ b_neg);
               neg_rem_d = special ? 1'b0 : a_neg;
               cnt_d     = CntW'(DATA_WIDTH - 1);
               if (special) begin
                  state_d = StDone;
               end else begin
                  state_d = is_div ? StDiv : StMul;
               end
            end
         end
         StMul, StDiv: begin
            if (flush_e) begin
               state_d = StIdle;
            end else begin
               step = 1'b1;
               if (cnt_q == '0) begin
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   md_iter_core #(
      .Width (W)
   ) u_core (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (load),
      .step_i     (step),
      .div_mode_i (state_q == StDiv),
      .acc_init_i (acc_init),
      .opd_init_i (opd_init),
      .acc_o      (acc)
   );

   // Sign fixup and result select; outputs depend on registered state only
   always_comb begin
      prod_fix    = neg_q ? -acc : acc;
      quo         = acc[W-1:0];
      rem         = acc[2*W-1:W];
      md_result_e = '0;
      if (state_q == StDone) begin
         unique case (op_q)
            MD_MUL:                       md_result_e = prod_fix[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_result_e = prod_fix[2*W-1:W];
            MD_DIV, MD_DIVU:              md_result_e = neg_q ? -quo : quo;
            MD_REM, MD_REMU:              md_result_e = neg_rem_q ? -rem : rem;
            default:                      md_result_e = '0;
         endcase
      end
   end

   assign done_e   = (state_q == StDone);
   assign stall_md = (((state_q == StIdle) && start_e) || (state_q == StMul) ||
                      (state_q == StDiv)) && !flush_e;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed corner cases plus random ops
// compared against an arithmetic reference model, cycle by cycle.
module tb_md_sequencer;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_e;
   logic [2:0]  funct3_e;
   logic [31:0] src_a_e;
   logic [31:0] src_b_e;
   logic        flush_e;
   logic        stall_md;
   logic        done_e;
   logic [31:0] md_result_e;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   md_sequencer #(
      .DATA_WIDTH (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_e     (start_e),
      .funct3_e    (funct3_e),
      .src_a_e     (src_a_e),
      .src_b_e     (src_b_e),
      .flush_e     (flush_e),
      .stall_md    (stall_md),
      .done_e      (done_e),
      .md_result_e (md_result_e)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RV32M semantics from 64-bit integer arithmetic
   function automatic logic [31:0] md_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      ia = $signed(a);
      ib = $signed(b);
      case (f)
         MD_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
         MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         MD_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         MD_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         MD_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         MD_DIVU: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         MD_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int op_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
      if (f[2] && (b == 32'd0)) return 1;
      if ((f == MD_DIV || f == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Entered #1 after a rising edge; that cycle is T. abort_kind: 0 none, 1 flush, 2 reset.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int abort_kind, input int abort_k, input bit scramble);
      logic [31:0] exp_res;
      int          lat;
      string       tag;
      exp_res  = md_model(f, a, b);
      lat      = op_latency(f, a, b);
      start_e  = 1'b1;
      funct3_e = f;
      src_a_e  = a;
      src_b_e  = b;
      flush_e  = 1'b0;
      for (int k = 0; k <= lat + 1; k++) begin
         if (k == lat + 1) start_e = 1'b0;
         if (abort_kind == 1 && k == abort_k) flush_e = 1'b1;
         if (abort_kind == 2 && k == abort_k) begin
            rst     = 1'b1;
            start_e = 1'b0;
         end
         @(negedge clk);
         tag = $sformatf("f%0d a=%h b=%h T+%0d", f, a, b, k);
         if (abort_kind == 2 && k == abort_k + 1) begin
            check_val({tag, " rst stall"}, {31'd0, stall_md}, 32'd0);
            check_val({tag, " rst done"}, {31'd0, done_e}, 32'd0);
            check_val({tag, " rst result"}, md_result_e, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            break;
         end
         if (abort_kind == 1 && k == abort_k) begin
            check_val({tag, " flush stall"}, {31'd0, stall_md}, 32'd0);
            check_val({tag, " flush done"}, {31'd0, done_e}, 32'd0);
            @(posedge clk);
            #1;
            flush_e = 1'b0;
            start_e = 1'b0;
            break;
         end
         check_val({tag, " stall"}, {31'd0, stall_md}, {31'd0, k < lat});
         check_val({tag, " done"}, {31'd0, done_e}, {31'd0, k == lat});
         check_val({tag, " result"}, md_result_e, (k == lat) ? exp_res : 32'd0);
         @(posedge clk);
         #1;
         if (scramble && k < lat) begin
            src_a_e  = $urandom;
            src_b_e  = $urandom;
            funct3_e = 3'($urandom_range(0, 7));
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      start_e  = 1'b0;
      flush_e  = 1'b0;
      funct3_e = 3'd0;
      src_a_e  = 32'd0;
      src_b_e  = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset stall", {31'd0, stall_md}, 32'd0);
      check_val("reset done", {31'd0, done_e}, 32'd0);
      check_val("reset result", md_result_e, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed cases
      run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, 0, 0, 1'b0);
      run_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, 0, 0, 1'b0);
      run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, 1'b0);
      run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         0, 0, 1'b0);
      run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         0, 0, 1'b0);
      run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         0, 0, 1'b0);
      run_op(MD_DIVU,   32'd100,        32'd7,         0, 0, 1'b0);
      run_op(MD_REMU,   32'd100,        32'd7,         0, 0, 1'b0);
      run_op(MD_DIVU,   32'd5,          32'd0,         0, 0, 1'b0);
      run_op(MD_REM,    32'd5,          32'd0,         0, 0, 1'b0);
      run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 0, 0, 1'b0);
      run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 0, 0, 1'b0);

      // Flush at T+10, then a new MUL accepted the very next cycle
      run_op(MD_MUL, 32'd123, 32'd456, 1, 10, 1'b0);
      run_op(MD_MUL, 32'd3,   32'd4,   0, 0,  1'b0);

      // Reset mid-op, then a normal op afterwards
      run_op(MD_DIV, 32'd1000, 32'd3, 2, 5, 1'b0);
      run_op(MD_REM, 32'hFFFF_FC18, 32'd7, 0, 0, 1'b0);

      // Inputs scrambled after capture must not disturb the result
      run_op(MD_MULH, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 1'b1);
      run_op(MD_DIV,  32'h8765_4321, 32'd13,        0, 0, 1'b1);

      // Random ops
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 0, 0,
                1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative RV32M multiply/divide unit and its sequencer, sitting alongside the main ALU in the execute stage. It accepts one M-extension operation from execute, runs a DATA_WIDTH-cycle shift-add multiply or restoring divide, and holds the F/D/E stages via a stall request until the result is ready. The result is then presented for one cycle so the instruction advances to memory with its final value.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: operand and result width. Iteration count equals DATA_WIDTH.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_e` in 1: valid M-op currently in execute. Held by the pipeline while stalled.
- `funct3_e` in [14:12]: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a_e` in DATA_WIDTH: rs1 value, post-forwarding.
- `src_b_e` in DATA_WIDTH: rs2 value, post-forwarding.
- `flush_e` in 1: kill the in-flight op (branch/jump redirect).
- `stall_md` out 1: request to stall F/D/E.
- `done_e` out 1: result valid this cycle.
- `md_result_e` out DATA_WIDTH: result; 0 whenever `done_e`=0.

## Operation

**FSM states:** IDLE, MUL, DIV, DONE.

**IDLE**
- `start_e`=1 and `flush_e`=0: capture operands and funct3 into internal registers. Later input changes are ignored.
- Compute operand magnitudes and result-sign flags per op: MULHSU treats only a as signed; the U variants are unsigned.
- Divide special cases skip straight to DONE:
  - b=0: quotient all-ones, remainder = a.
  - Signed a=0x80000000, b=-1: quotient 0x80000000, remainder 0.
- Otherwise go to MUL (funct3[14]=0) or DIV (funct3[14]=1) and load the iteration counter with DATA_WIDTH-1.

**MUL**
- One shift-add step per cycle into a 2·DATA_WIDTH accumulator.
- Counter decrements; at counter 0, go to DONE.

**DIV**
- One restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- Counter 0 → DONE.

**DONE**
- `done_e`=1. `md_result_e` = sign-fixed registered raw result: low half for MUL, high half for MULH*, quotient for DIV/DIVU, remainder for REM/REMU.
  - Quotient negative iff signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Always go to IDLE next cycle, even though `start_e` is still high for the same instruction. No restart.

**Stall**
- `stall_md` = ((IDLE & `start_e`) | MUL | DIV) & ~`flush_e`.
- `stall_md` is 0 in DONE.

**Flush**
- `flush_e`=1 in any state: next state IDLE, `done_e` never asserted for that op, `stall_md` 0 that cycle.

**Reset**
- State IDLE; counter, accumulators, captured operands, and sign flags all 0.
- `stall_md`=0, `done_e`=0, `md_result_e`=0.
- Reset mid-operation abandons the op with no done pulse.

**Arithmetic**
- All internal magnitudes are unsigned DATA_WIDTH.
- Negation is two's complement, modulo 2^DATA_WIDTH.

## Timing

- Start accepted at cycle T (IDLE).
- Normal ops:
  - Iterations run T+1 … T+DATA_WIDTH.
  - DONE at T+DATA_WIDTH+1 (T+33 for 32-bit).
  - `stall_md` high T … T+32, i.e. 33 cycles.
- Special-case divides: DONE at T+1; `stall_md` high at T only.
- A back-to-back M-op reaches execute at T+34 (T+2 for special cases) and is accepted in IDLE that same cycle.
- `flush_e` and `start_e` both high in IDLE: the flush wins and nothing is captured.
- `stall_md` is combinational from state, `start_e`, and `flush_e`.
- `md_result_e` and `done_e` are decoded from registered state only; there is no combinational path from the inputs.

## Structure

- **Package `md_pkg`:**
  - funct3 constants (MD_MUL … MD_REMU).
  - FSM state typedef (IDLE/MUL/DIV/DONE).
  - Iteration-count localparam.
- **Sub-module `md_iter_core`:**
  - Holds the accumulator/remainder/quotient registers and one-step shift-add / restoring-subtract logic, selected by a mode bit.
  - Has load and step enables driven by the FSM in md_sequencer.
- **md_sequencer owns:**
  - FSM and counter.
  - Operand capture and sign/special-case detection.
  - Final sign fixup and result mux.

## Test plan

- **MUL signed:** MUL a=7, b=0xFFFFFFFD at T → `stall_md` high T…T+32, `done_e` only at T+33, `md_result_e`=0xFFFFFFEB; IDLE at T+34.
- **High-half multiplies:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- **Signed divide/remainder:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
  - All with `done_e` at T+33.
- **Special cases:**
  - DIVU 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - `stall_md` high at T only.
- **Flush/reset mid-op:**
  - `flush_e` at T+10 → `stall_md` 0 at T+10, IDLE at T+11, no `done_e`. A new MUL 3×4 started at T+11 returns 12 at T+44.
  - `rst` at T+5 → all outputs 0 next cycle, no `done_e`.
- **Operand hold:** change `src_a_e`/`src_b_e` after T → result unaffected. `start_e` held high through DONE → exactly one `done_e` pulse, no re-issue.
